// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, engine status/error, scheduler FSM states and
// the channel-count ceiling used by the channel scheduler.
package dma_pkg;

  localparam int DMA_SCHED_MAX_CH = 8;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic active;
    logic done;
    logic error;
  } s_dma_status_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } s_dma_error_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_RUN,
    SCHED_CMPL
  } e_sched_state_t;

  function automatic logic [2:0] oh2idx(input logic [DMA_SCHED_MAX_CH-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < DMA_SCHED_MAX_CH; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin picker: first pending channel at or after ptr_i,
// wrapping from NUM_CH-1 back to 0.
module dma_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         pending_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic                      valid_o
);

  localparam int PW = $clog2(NUM_CH);

  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = PW'((32'(ptr_i) + i) % NUM_CH);
      if (!valid_o && pending_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// Multi-channel front end for a single DMA engine with round-robin service.
// Define DMA_SCHED_WDOG_EN to abort RUN after WDOG_CYCLES cycles with an error.
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_go_i,
  input  s_dma_desc_t         ch_desc_i [NUM_CH],
  output logic [NUM_CH-1:0]   ch_busy_o,
  output logic [NUM_CH-1:0]   ch_done_o,
  output logic [NUM_CH-1:0]   ch_error_o,
  output logic [NUM_CH-1:0]   ch_reject_o,
  output logic                eng_go_o,
  output s_dma_desc_t         eng_desc_o,
  input  s_dma_status_t       eng_stats_i,
  input  s_dma_error_t        eng_error_i
);

  localparam int PW = $clog2(NUM_CH);

  e_sched_state_t state_q;
  logic [NUM_CH-1:0] pending_q, pending_d, accept, err_set;
  logic [NUM_CH-1:0] gnt_oh, gnt_oh_q, done_q, err_q, rej_q;
  logic [DMA_SCHED_MAX_CH-1:0] gnt_oh_ext;
  logic [PW-1:0] gnt_idx, rr_ptr_q;
  logic          gnt_valid, go_q, wdog_hit, unused_ok;
  s_dma_desc_t   slot_q [NUM_CH];
  s_dma_desc_t   desc_q;

  dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending_i (pending_q),
    .ptr_i     (rr_ptr_q),
    .grant_o   (gnt_oh),
    .valid_o   (gnt_valid)
  );

  assign gnt_oh_ext = DMA_SCHED_MAX_CH'(gnt_oh);
  assign gnt_idx    = PW'(oh2idx(gnt_oh_ext));

`ifdef DMA_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != SCHED_RUN) wdog_q <= '0;
    else                             wdog_q <= wdog_q + WD_W'(1);
  end

  assign wdog_hit  = (state_q == SCHED_RUN) && (wdog_q == WD_W'(WDOG_CYCLES - 1));
  assign unused_ok = ^eng_error_i;
`else
  assign wdog_hit  = 1'b0;
  assign unused_ok = ^eng_error_i ^ (WDOG_CYCLES != 0);
`endif

  // pending covers both queued and in-flight; it clears only in CMPL, so busy
  // stays high through the done pulse and repeat gos are rejected meanwhile.
  always_comb begin
    accept    = ch_go_i & ~pending_q;
    pending_d = pending_q | accept;
    if (state_q == SCHED_CMPL) pending_d = pending_d & ~gnt_oh_q;
    err_set = '0;
    if (state_q == SCHED_RUN && (eng_stats_i.error || wdog_hit)) err_set = gnt_oh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCHED_IDLE;
      pending_q <= '0;
      gnt_oh_q  <= '0;
      rr_ptr_q  <= '0;
      go_q      <= 1'b0;
      desc_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rej_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      rej_q     <= ch_go_i & pending_q;
      err_q     <= (err_q & ~accept) | err_set;
      done_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (accept[i]) slot_q[i] <= ch_desc_i[i];
      end
      case (state_q)
        SCHED_IDLE: begin
          if (gnt_valid) begin
            gnt_oh_q <= gnt_oh;
            desc_q   <= slot_q[gnt_idx];
            go_q     <= (slot_q[gnt_idx].num_bytes != '0);
            state_q  <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          if (desc_q.num_bytes == '0) begin
            done_q  <= gnt_oh_q;
            state_q <= SCHED_CMPL;
          end else if (eng_stats_i.active) begin
            go_q    <= 1'b0;
            state_q <= SCHED_RUN;
          end
        end
        SCHED_RUN: begin
          if (eng_stats_i.done || eng_stats_i.error || wdog_hit) begin
            done_q  <= gnt_oh_q;
            state_q <= SCHED_CMPL;
          end
        end
        SCHED_CMPL: begin
          rr_ptr_q <= (oh2idx(DMA_SCHED_MAX_CH'(gnt_oh_q)) == 3'(NUM_CH - 1)) ? '0
                    : PW'(oh2idx(DMA_SCHED_MAX_CH'(gnt_oh_q)) + 3'd1);
          state_q  <= SCHED_IDLE;
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  assign ch_busy_o   = pending_q;
  assign ch_done_o   = done_q;
  assign ch_error_o  = err_q;
  assign ch_reject_o = rej_q;
  assign eng_go_o    = go_q;
  assign eng_desc_o  = desc_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: table of single transfers followed by
// round-robin, reject, reset and (with DMA_SCHED_WDOG_EN) watchdog sequences.
module tb_dma_chan_sched;
  import dma_pkg::*;

  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NCH-1:0] ch_go;
  s_dma_desc_t   ch_desc [NCH];
  logic [NCH-1:0] busy, done, err, rej;
  logic          eng_go;
  s_dma_desc_t   eng_desc;
  s_dma_status_t stats;
  s_dma_error_t  eerr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dma_chan_sched #(.NUM_CH(NCH), .WDOG_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_go_i     (ch_go),
    .ch_desc_i   (ch_desc),
    .ch_busy_o   (busy),
    .ch_done_o   (done),
    .ch_error_o  (err),
    .ch_reject_o (rej),
    .eng_go_o    (eng_go),
    .eng_desc_o  (eng_desc),
    .eng_stats_i (stats),
    .eng_error_i (eerr)
  );

  typedef struct {
    int          ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] nb;
    logic        eng_err;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_go();
    for (int k = 0; k < 20 && !eng_go; k++) tick();
    check("go_seen", eng_go, 1);
  endtask

  // Engine stand-in: accept the go, run two cycles, report done.
  task automatic serve(output int ch);
    wait_go();
    ch = int'(eng_desc.src_addr[3:0]);
    stats.active = 1'b1; tick(); stats.active = 1'b0;
    tick();
    stats.done = 1'b1; tick(); stats.done = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [NCH-1:0] oh;
    s_dma_desc_t d;
    int cyc;
    logic saw_go;
    oh = '0;
    oh[v.ch] = 1'b1;
    d = '{src_addr: v.src, dst_addr: v.dst, num_bytes: v.nb};
    ch_desc[v.ch] = d;
    ch_go = oh;
    tick();
    ch_go = '0;
    check("busy_after_go", busy, oh);
    if (v.nb != 0) begin
      wait_go();
      check("eng_desc", eng_desc, d);
      stats.active = 1'b1; tick(); stats.active = 1'b0;
      check("go_dropped", eng_go, 0);
      tick(); tick();
      check("desc_stable_run", eng_desc, d);
      check("no_early_done", done, 0);
      stats.done = 1'b1; stats.error = v.eng_err; tick();
      stats.done = 1'b0; stats.error = 1'b0;
    end else begin
      saw_go = eng_go;
      cyc = 1;
      while (done == '0 && cyc < 3) begin
        tick();
        cyc++;
        saw_go |= eng_go;
      end
      check("zero_len_no_go", saw_go, 0);
    end
    check("done_pulse", done, oh);
    check("busy_incl_done", busy, oh);
    check("error_vec", err, v.exp_err);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int g;
    int exp1 [4];
    int exp2 [4];
    s_dma_desc_t da, db;

    exp1 = '{0, 1, 2, 3};
    exp2 = '{1, 2, 3, 0};
    vecs[0] = '{ch: 2, src: 32'h1100_0100, dst: 32'h1400_0100, nb: 32'h100, eng_err: 1'b0, exp_err: 4'b0000};
    vecs[1] = '{ch: 0, src: 32'h1100_0200, dst: 32'h1400_0200, nb: 32'h40,  eng_err: 1'b1, exp_err: 4'b0001};
    vecs[2] = '{ch: 1, src: 32'h1100_0300, dst: 32'h1400_0300, nb: 32'h8,   eng_err: 1'b0, exp_err: 4'b0001};
    vecs[3] = '{ch: 3, src: 32'h1100_0400, dst: 32'h1400_0400, nb: 32'h0,   eng_err: 1'b0, exp_err: 4'b0001};

    rst = 1'b1;
    ch_go = '0;
    stats = '0;
    eerr = '0;
    for (int i = 0; i < NCH; i++) ch_desc[i] = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rej", rej, 0);
    check("rst_go", eng_go, 0);
    check("rst_desc", eng_desc, 0);

    ch_go = 4'b0001;
    tick();
    ch_go = '0;
    rst = 1'b0;
    tick();
    check("go_ignored_in_rst", busy, 0);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i]);

    for (int i = 0; i < NCH; i++)
      ch_desc[i] = '{src_addr: 32'h2000_0000 + i, dst_addr: 32'h3000_0000 + i, num_bytes: 32'h10};
    ch_go = '1; tick(); ch_go = '0;
    check("rr_busy_all", busy, 4'hF);
    check("err_cleared_on_go", err, 0);
    for (int i = 0; i < NCH; i++) begin
      serve(g);
      check("rr_round1", g, exp1[i]);
    end
    tick();
    check("rr_idle", busy, 0);

    ch_go = 4'b0001; tick(); ch_go = '0;
    serve(g);
    check("rr_single_ch0", g, 0);
    tick();
    ch_go = '1; tick(); ch_go = '0;
    for (int i = 0; i < NCH; i++) begin
      serve(g);
      check("rr_round2", g, exp2[i]);
    end
    tick();

    da = '{src_addr: 32'h5000_0001, dst_addr: 32'h6000_0001, num_bytes: 32'h20};
    db = '{src_addr: 32'h7000_0001, dst_addr: 32'h8000_0001, num_bytes: 32'h44};
    ch_desc[1] = da;
    ch_go = 4'b0010; tick(); ch_go = '0;
    wait_go();
    check("rej_desc_a", eng_desc, da);
    stats.active = 1'b1; tick(); stats.active = 1'b0;
    ch_desc[1] = db;
    ch_go = 4'b0010; tick(); ch_go = '0;
    check("reject_pulse", rej, 4'b0010);
    check("rej_desc_kept", eng_desc, da);
    tick();
    check("reject_one_cycle", rej, 0);
    stats.done = 1'b1; tick(); stats.done = 1'b0;
    check("rej_done", done, 4'b0010);
    tick();
    check("rej_no_requeue", busy, 0);

    ch_desc[0] = '{src_addr: 32'h2000_0000, dst_addr: 32'h3000_0000, num_bytes: 32'h10};
    ch_desc[1] = '{src_addr: 32'h2000_0001, dst_addr: 32'h3000_0001, num_bytes: 32'h10};
    ch_desc[3] = '{src_addr: 32'h2000_0003, dst_addr: 32'h3000_0003, num_bytes: 32'h10};
    ch_go = 4'b0011; tick(); ch_go = '0;
    wait_go();
    check("midrun_grant_ch0", eng_desc.src_addr, 32'h2000_0000);
    stats.active = 1'b1; tick(); stats.active = 1'b0;
    rst = 1'b1;
    ch_go = 4'b1000;
    tick();
    rst = 1'b0;
    ch_go = '0;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_err", err, 0);
    check("midrun_rst_rej", rej, 0);
    check("midrun_rst_go", eng_go, 0);
    check("midrun_rst_desc", eng_desc, 0);
    tick();
    check("post_rst_idle", {busy, eng_go}, 0);
    ch_go = 4'b1010; tick(); ch_go = '0;
    serve(g);
    check("post_rst_ptr0_first", g, 1);
    serve(g);
    check("post_rst_second", g, 3);
    tick();

`ifdef DMA_SCHED_WDOG_EN
    begin
      int cnt;
      ch_desc[2] = '{src_addr: 32'h2000_0002, dst_addr: 32'h3000_0002, num_bytes: 32'h10};
      ch_go = 4'b0100; tick(); ch_go = '0;
      wait_go();
      stats.active = 1'b1; tick(); stats.active = 1'b0;
      cnt = 0;
      while (done == '0 && cnt < 40) begin
        tick();
        cnt++;
      end
      check("wdog_cycles", cnt, 16);
      check("wdog_done", done, 4'b0100);
      check("wdog_error", err, 4'b0100);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
